operand_fwd_stage: RTL

Parametrised operand-forwarding stage for the pipelined CPU. It is the generalised, registered successor to the fixed 3-input, 2-bit forwarding select: the block compares a source register number against the destination registers of NUM_STAGES younger pipeline stages and picks the youngest matching result, falling back to the register-file value. It registers the chosen operand into the EX pipeline register with stall, flush and bubble handling, and flags load-use hazards. One instance per ALU operand.

---
 rtl/operand_fwd_pkg.sv | 19 +
 rtl/fwd_prio_sel.sv | 47 ++++
 rtl/operand_fwd_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/operand_fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : operand_fwd_pkg
// Description : Shared constants and width helper for the operand forwarding
//               stage.
// Revision    : 1.0 - initial release
// ============================================================================
package operand_fwd_pkg;

    localparam int STAT_W = 16;
    localparam int SEL_RF = 0;

    // Select code width: one code for the register file plus one per stage.
    function automatic int sel_w_of(input int num_stages);
        return (num_stages < 1) ? 1 : $clog2(num_stages + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_prio_sel.sv
`default_nettype none
// ============================================================================
// Module      : fwd_prio_sel
// Description : Combinational priority matcher; the youngest writing stage
//               whose destination equals the source register wins.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_prio_sel
    import operand_fwd_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int REG_BITS   = 5,
    parameter int ZERO_REG   = 31,
    parameter int SEL_W      = 2
) (
    input  logic [REG_BITS-1:0]                  i_src_reg,
    input  logic [NUM_STAGES-1:0]                i_stg_wr,
    input  logic [NUM_STAGES-1:0][REG_BITS-1:0]  i_stg_dest,
    output logic                                 o_match_vld,
    output logic [SEL_W-1:0]                     o_sel,
    output logic                                 o_match0
);

    logic [NUM_STAGES-1:0] w_hit;
    logic                  w_is_zero;

    assign w_is_zero = (i_src_reg == REG_BITS'(ZERO_REG));

    generate
        for (genvar k = 0; k < NUM_STAGES; k++) begin : g_hit
            assign w_hit[k] = i_stg_wr[k] && (i_stg_dest[k] == i_src_reg) && !w_is_zero;
        end
    endgenerate

    // Walk from oldest to youngest so the lowest matching index overwrites last.
    always_comb begin
        o_sel = SEL_W'(SEL_RF);
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (w_hit[k]) o_sel = SEL_W'(k + 1);
        end
    end

    assign o_match_vld = |w_hit;
    assign o_match0    = w_hit[0];

endmodule
`default_nettype wire

// File: rtl/operand_fwd_stage.sv
`default_nettype none
// ============================================================================
// Module      : operand_fwd_stage
// Description : Registered operand forwarding into the EX pipeline register
//               with stall/flush/bubble handling and load-use hazard detect.
//               OPERAND_FWD_STATS_EN adds saturating forward/hazard counters.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fwd_stage
    import operand_fwd_pkg::*;
#(
    parameter  int WIDTH      = 64,
    parameter  int NUM_STAGES = 3,
    parameter  int REG_BITS   = 5,
    parameter  int ZERO_REG   = 31,
    localparam int SEL_W      = sel_w_of(NUM_STAGES)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    input  logic [REG_BITS-1:0]                  src_reg,
    input  logic [WIDTH-1:0]                     rf_data,
    input  logic [NUM_STAGES-1:0]                stg_wr,
    input  logic [NUM_STAGES-1:0][REG_BITS-1:0]  stg_dest,
    input  logic [NUM_STAGES-1:0][WIDTH-1:0]     stg_data,
    input  logic                                 ex_is_load,
    input  logic                                 stall_in,
    input  logic                                 flush_in,
    output logic                                 hazard,
    output logic [WIDTH-1:0]                     op_out,
    output logic                                 op_valid,
    output logic [SEL_W-1:0]                     op_sel
`ifdef OPERAND_FWD_STATS_EN
    ,
    output logic [NUM_STAGES-1:0][STAT_W-1:0]    fwd_cnt,
    output logic [STAT_W-1:0]                    haz_cnt
`endif
);

    logic             w_match_vld;
    logic             w_match0;
    logic [SEL_W-1:0] w_sel;
    logic             w_is_zero;
    logic [WIDTH-1:0] w_next_data;

    logic [WIDTH-1:0] r_op_out;
    logic             r_op_valid;
    logic [SEL_W-1:0] r_op_sel;

    fwd_prio_sel #(
        .NUM_STAGES (NUM_STAGES),
        .REG_BITS   (REG_BITS),
        .ZERO_REG   (ZERO_REG),
        .SEL_W      (SEL_W)
    ) u_prio (
        .i_src_reg   (src_reg),
        .i_stg_wr    (stg_wr),
        .i_stg_dest  (stg_dest),
        .o_match_vld (w_match_vld),
        .o_sel       (w_sel),
        .o_match0    (w_match0)
    );

    assign w_is_zero = (src_reg == REG_BITS'(ZERO_REG));

    always_comb begin
        w_next_data = rf_data;
        if (w_is_zero) begin
            w_next_data = '0;
        end else if (w_match_vld) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (w_sel == SEL_W'(k + 1)) w_next_data = stg_data[k];
            end
        end
    end

    // Stall-independent so the front end can hold decode before the edge.
    assign hazard = in_valid && w_match0 && ex_is_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_out   <= '0;
            r_op_valid <= 1'b0;
            r_op_sel   <= SEL_W'(SEL_RF);
        end else if (flush_in) begin
            r_op_out   <= '0;
            r_op_valid <= 1'b0;
            r_op_sel   <= SEL_W'(SEL_RF);
        end else if (stall_in) begin
            r_op_out   <= r_op_out;
            r_op_valid <= r_op_valid;
            r_op_sel   <= r_op_sel;
        end else if (hazard) begin
            r_op_valid <= 1'b0;
            r_op_sel   <= SEL_W'(SEL_RF);
        end else begin
            r_op_out   <= w_next_data;
            r_op_valid <= in_valid;
            r_op_sel   <= w_sel;
        end
    end

    assign op_out   = r_op_out;
    assign op_valid = r_op_valid;
    assign op_sel   = r_op_sel;

`ifdef OPERAND_FWD_STATS_EN
    logic [NUM_STAGES-1:0][STAT_W-1:0] r_fwd_cnt;
    logic [STAT_W-1:0]                 r_haz_cnt;
    logic                              w_capture;

    assign w_capture = !flush_in && !stall_in && !hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_cnt <= '0;
            r_haz_cnt <= '0;
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (w_capture && in_valid && (w_sel == SEL_W'(k + 1)) && (r_fwd_cnt[k] != '1))
                    r_fwd_cnt[k] <= r_fwd_cnt[k] + 1'b1;
            end
            if (hazard && !flush_in && !stall_in && (r_haz_cnt != '1))
                r_haz_cnt <= r_haz_cnt + 1'b1;
        end
    end

    assign fwd_cnt = r_fwd_cnt;
    assign haz_cnt = r_haz_cnt;
`endif

endmodule
`default_nettype wire
